// File: rtl/rv_muldiv_unit.sv
// Iterative RV32IM multiply/divide unit: radix-2^BITS_PER_CYCLE shift-add multiply
// and restoring divide on operand magnitudes, with sign fix-up in a final cycle.
module rv_muldiv_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_A,
  input  logic [DATA_WIDTH-1:0] operand_B,
  input  logic                  kill,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  hold_pipeline
);

  localparam int unsigned N  = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned SW = DATA_WIDTH + BITS_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic                  neg_a_q, neg_a_d;
  logic                  neg_b_q, neg_b_d;
  logic [DATA_WIDTH-1:0] m_q, m_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic                    accept;
  logic                    in_sa, in_sb;
  logic [DATA_WIDTH-1:0]   a_mag, b_mag;
  logic [DATA_WIDTH-1:0]   most_neg;
  logic [SW-1:0]           mul_sum;
  logic [DATA_WIDTH:0]     rem_w;
  logic [DATA_WIDTH-1:0]   div_r, div_q;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]   quot, rem;

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign result        = result_q;
  assign zero          = out_valid & (result_q == '0);
  assign hold_pipeline = (state_q == CALC) | (state_q == FIX) |
                         ((state_q == IDLE) & in_valid) |
                         ((state_q == DONE) & ~out_ready);

  assign accept   = in_valid & in_ready;
  assign most_neg = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  // A is signed except for MULHU/DIVU/REMU; B is signed only for MUL/MULH/DIV/REM.
  assign in_sa = operand_A[DATA_WIDTH-1] & ~(op == 3'b011 || op == 3'b101 || op == 3'b111);
  assign in_sb = operand_B[DATA_WIDTH-1] & (op == 3'b000 || op == 3'b001 ||
                                           op == 3'b100 || op == 3'b110);
  assign a_mag = in_sa ? (~operand_A + 1'b1) : operand_A;
  assign b_mag = in_sb ? (~operand_B + 1'b1) : operand_B;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    mul_sum  = '0;
    rem_w    = '0;
    div_r    = hi_q;
    div_q    = lo_q;
    prod     = {hi_q, lo_q};
    quot     = lo_q;
    rem      = hi_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = op;
          neg_a_d = in_sa;
          neg_b_d = in_sb;
          cnt_d   = CW'(N);
          hi_d    = '0;
          if (op[2] && operand_B == '0) begin
            result_d = op[1] ? operand_A : '1;
            state_d  = DONE;
          end else if (op[2] && !op[0] && operand_A == most_neg && operand_B == '1) begin
            result_d = op[1] ? '0 : operand_A;
            state_d  = DONE;
          end else if (op[2]) begin
            m_d     = b_mag;
            lo_d    = a_mag;
            state_d = CALC;
          end else begin
            m_d     = a_mag;
            lo_d    = b_mag;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (op_q[2]) begin
            for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
              rem_w = {div_r, div_q[DATA_WIDTH-1]};
              div_q = {div_q[DATA_WIDTH-2:0], 1'b0};
              if (rem_w >= {1'b0, m_q}) begin
                rem_w    = rem_w - {1'b0, m_q};
                div_q[0] = 1'b1;
              end
              div_r = rem_w[DATA_WIDTH-1:0];
            end
            hi_d = div_r;
            lo_d = div_q;
          end else begin
            // hi accumulates m * (next multiplier digit); {hi,lo} then shifts right one digit.
            mul_sum = {{BITS_PER_CYCLE{1'b0}}, hi_q} +
                      ({{BITS_PER_CYCLE{1'b0}}, m_q} *
                       {{DATA_WIDTH{1'b0}}, lo_q[BITS_PER_CYCLE-1:0]});
            hi_d = mul_sum[SW-1:BITS_PER_CYCLE];
            lo_d = {mul_sum[BITS_PER_CYCLE-1:0], lo_q[DATA_WIDTH-1:BITS_PER_CYCLE]};
          end
        end
      end
      FIX: begin
        if (op_q[2]) begin
          if (neg_a_q ^ neg_b_q) quot = ~lo_q + 1'b1;
          if (neg_a_q)           rem  = ~hi_q + 1'b1;
          result_d = op_q[1] ? rem : quot;
        end else begin
          if (neg_a_q ^ neg_b_q) prod = ~{hi_q, lo_q} + 1'b1;
          result_d = (op_q[1:0] == 2'b00) ? prod[DATA_WIDTH-1:0]
                                          : prod[2*DATA_WIDTH-1:DATA_WIDTH];
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (kill) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Randomised self-checking bench for rv_muldiv_unit: radix-2 and radix-4 instances
// against a plain-arithmetic RV32M reference model.
module tb_rv_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_valid, in_ready, kill, out_valid, out_ready, zero, hold;
  logic [2:0]  op  [2];
  logic [31:0] a   [2];
  logic [31:0] b   [2];
  logic [31:0] res [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv_muldiv_unit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .op(op[0]), .operand_A(a[0]), .operand_B(b[0]), .kill(kill[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(res[0]),
    .zero(zero[0]), .hold_pipeline(hold[0])
  );

  rv_muldiv_unit #(.DATA_WIDTH(32), .BITS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .op(op[1]), .operand_A(a[1]), .operand_B(b[1]), .kill(kill[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(res[1]),
    .zero(zero[1]), .hold_pipeline(hold[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint      sx, sy, ux, uy;
    logic [63:0] p;
    int          ix, iy;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    ix = x;
    iy = y;
    case (o)
      3'd0: begin p = sx * sy; return p[31:0];  end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      default: begin
        if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : x;
        case (o)
          3'd4:    return ix / iy;
          3'd5:    return x / y;
          3'd6:    return ix % iy;
          default: return x % y;
        endcase
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return o[2] && (y == 32'd0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  // Issue one op on instance s, measure edges from accept to out_valid, check, then retire.
  task automatic run_op(input int s, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int stall);
    logic [31:0] e;
    int          lat, explat;
    bit          hold_ok;
    e      = ref_result(o, x, y);
    explat = is_fast(o, x, y) ? 0 : ((s == 0) ? 34 : 18);
    @(negedge clk);
    op[s] = o; a[s] = x; b[s] = y; in_valid[s] = 1'b1;
    #1 check("hold_req", hold[s], 1);
    @(posedge clk);
    #1 in_valid[s] = 1'b0;
    lat     = 0;
    hold_ok = 1'b1;
    while (!out_valid[s] && lat < 100) begin
      if (!hold[s]) hold_ok = 1'b0;
      @(posedge clk);
      #1 lat++;
    end
    check($sformatf("latency op%0d", o), lat, explat);
    check("hold_busy", hold_ok, 1);
    check($sformatf("result op%0d %h %h", o, x, y), res[s], e);
    check("zero", zero[s], (e == 32'd0));
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
      check("stall_result", res[s], e);
      check("stall_valid", out_valid[s], 1);
      check("stall_hold", hold[s], 1);
    end
    @(negedge clk);
    out_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    check("retire_valid", out_valid[s], 0);
    check("retire_ready", in_ready[s], 1);
    out_ready[s] = 1'b0;
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    bit quiet;
    quiet = 1'b1;
    repeat (cycles) begin
      @(posedge clk);
      #1 if (out_valid[0]) quiet = 1'b0;
    end
    check(tag, quiet, 1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    in_valid = '0; kill = '0; out_ready = '0;
    for (int i = 0; i < 2; i++) begin
      op[i] = '0; a[i] = '0; b[i] = '0;
    end
    #12;
    check("rst_in_ready", in_ready, 2'b11);
    check("rst_out_valid", out_valid, 2'b00);
    check("rst_result", res[0], 0);
    check("rst_zero", zero, 2'b00);
    check("rst_hold", hold, 2'b00);
    @(negedge clk) rst_n = 1'b1;

    run_op(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(0, 3'd2, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(0, 3'd5, 32'd100, 32'd7, 0);
    run_op(0, 3'd7, 32'd100, 32'd7, 0);
    run_op(0, 3'd5, 32'd5, 32'd0, 0);
    run_op(0, 3'd6, 32'd5, 32'd0, 0);
    run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(0, 3'd0, 32'd9, 32'd11, 10);
    run_op(1, 3'd0, 32'd7, 32'hFFFF_FFFD, 0);

    // kill mid-CALC
    @(negedge clk);
    op[0] = 3'd0; a[0] = 32'd3; b[0] = 32'd4; in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) kill[0] = 1'b1;
    @(posedge clk);
    #1;
    check("kill_idle", in_ready[0], 1);
    check("kill_valid", out_valid[0], 0);
    kill[0] = 1'b0;
    watch_quiet("kill_quiet", 40);

    // kill on the accept edge
    @(negedge clk);
    in_valid[0] = 1'b1; kill[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0; kill[0] = 1'b0;
    check("kill_accept_idle", in_ready[0], 1);
    watch_quiet("kill_accept_quiet", 40);
    run_op(0, 3'd0, 32'd3, 32'd4, 0);

    // async reset mid-CALC
    @(negedge clk);
    op[0] = 3'd4; a[0] = 32'd1000; b[0] = 32'd3; in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ready", in_ready[0], 1);
    check("rst_mid_valid", out_valid[0], 0);
    check("rst_mid_result", res[0], 0);
    @(negedge clk) rst_n = 1'b1;
    watch_quiet("rst_mid_quiet", 40);
    run_op(0, 3'd0, 32'd3, 32'd4, 0);

    for (int i = 0; i < 150; i++) begin
      run_op($urandom_range(0, 1), 3'($urandom_range(0, 7)), pick(), pick(),
             $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
